mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for a shared 4:1 mux datapath. Four requesters
//  (a,b,c,d) compete for the one output. The block picks a winner, drives the mux
//  select, and registers the winner's data into an output stage with a valid/ready
//  handshake. Sits between the requester interfaces and the downstream consumer.
// PARAMETERS
//  DW       4    data width of each requester input and of y_data
//  CNT_W    16   width of the accepted-transfer counter xfer_cnt
// PORTS
//  clk      in   1      single clock; all state updates on posedge
//  rst      in   1      asynchronous, active-high reset
//  req      in   4      request per source; bit0=a, bit1=b, bit2=c, bit3=d
//  a,b,c,d  in   DW     source data; held stable while the matching req is high
//  gnt      out  4      one-hot grant, combinational; high in the capture cycle only
//  sel      out  2      registered mux select of the data currently held in y_data
//  y_data   out  DW     registered output data
//  y_valid  out  1      y_data holds an unaccepted transfer
//  y_ready  in   1      downstream accepts y_data when y_valid && y_ready
//  xfer_cnt out  CNT_W  count of accepted transfers; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; sel=0; y_data=0; y_valid=0; ptr=0;
//   xfer_cnt=0. gnt=0 while rst=1. Reset mid-transfer drops the held data.
//  ptr (2b, internal) = priority start index. Winner = first i with req[i]=1 in the
//   order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  Capture enable cap = (state==IDLE || (y_valid && y_ready)) && |req.
//  On a capture cycle: gnt[winner]=1 (combinational). At posedge: y_data <= selected
//   input, sel <= winner, y_valid <= 1, ptr <= winner+1 (mod 4).
//  gnt is 0 in every cycle without cap. This includes a VALID cycle with
//   y_ready=0.
//  States:
//   IDLE : y_valid=0.
//          If cap: go to VALID.
//          Else: stay in IDLE.
//   VALID: y_valid=1; y_data and sel held stable while y_ready=0.
//          If y_ready && cap: recapture and stay in VALID.
//           Throughput is one transfer per clock.
//          If y_ready && !cap: y_valid <= 0 and go to IDLE.
//  Latency: a request seen in IDLE at edge N gives y_valid=1 after edge N.
//  Requester protocol: hold req and data until a cycle with gnt[i]=1.
//   Drop req the cycle after the grant, or keep it high for another transfer.
//   Holding req never starves others; ptr moves past each winner.
//  xfer_cnt increments by 1 at every edge where y_valid && y_ready.
//   It wraps from 2^CNT_W-1 to 0.
//  Simultaneous accept and new req is the recapture case above: no bubble.
//  y_ready while y_valid=0 is ignored.
// TESTING
//  1 Reset: assert rst mid-VALID
//     -> y_valid, sel, y_data, xfer_cnt, gnt all 0 immediately, before any clock.
//  2 Single request: req=0010, b=4'hA, y_ready=1
//     -> gnt=0010 in the capture cycle.
//     -> Next cycle: y_valid=1, y_data=A, sel=1, xfer_cnt=1 after accept.
//  3 Fairness: req=1111 held, y_ready=1, a..d=1,2,3,4
//     -> grant order a,b,c,d,a,...
//     -> y_data stream 1,2,3,4,1 on consecutive cycles, no bubbles.
//  4 Backpressure: y_ready=0 with req=0101
//     -> y_data holds the first winner; gnt=0 throughout the stall.
//     -> On y_ready=1, c is granted next (ptr past a).
//  5 Idle return: single transfer accepted with req=0
//     -> y_valid drops the next cycle; state is IDLE; gnt=0.
//  6 Counter wrap (CNT_W=4): 17 accepted transfers -> xfer_cnt reads 1.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and output register stage for a shared 4:1 mux datapath.
// Four requesters compete for one registered output slot with a valid/ready
// handshake. The priority pointer moves past each winner, so a requester that
// holds req high cannot starve the others.
module mux_rr_arbiter #(
    parameter int unsigned DW    = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [DW-1:0]    c,
    input  logic [DW-1:0]    d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [DW-1:0]    y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [DW-1:0]      y_data_q, y_data_d;
    logic               y_valid_q, y_valid_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   scan_idx;
    logic               found;
    logic [DW-1:0]      mux_out;
    logic               accept;
    logic               cap;

    // Rotating priority scan: first requester at or after ptr wins.
    always_comb begin
        winner   = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ptr_q + IDX_W'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Shared 4:1 data mux steered by the current winner.
    always_comb begin
        mux_out = a;
        case (winner)
            2'd0:    mux_out = a;
            2'd1:    mux_out = b;
            2'd2:    mux_out = c;
            2'd3:    mux_out = d;
            default: mux_out = a;
        endcase
    end

    // Output slot is free when empty or being drained this cycle.
    always_comb begin
        accept = y_valid_q && y_ready;
        cap    = ((state_q == IDLE) || accept) && (|req);
        gnt    = (cap && !rst) ? (4'b0001 << winner) : 4'b0000;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        y_data_d   = y_data_q;
        y_valid_d  = y_valid_q;
        xfer_cnt_d = xfer_cnt_q;

        case (state_q)
            IDLE: begin
                if (cap) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (accept && !cap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap) begin
            y_data_d  = mux_out;
            sel_d     = winner;
            y_valid_d = 1'b1;
            ptr_d     = winner + IDX_W'(1);
        end else if (accept) begin
            y_valid_d = 1'b0;
        end

        if (accept) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers; reset discards any held transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            y_data_q   <= '0;
            y_valid_q  <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            y_data_q   <= y_data_d;
            y_valid_q  <= y_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Registered outputs.
    always_comb begin
        sel      = sel_q;
        y_data   = y_data_q;
        y_valid  = y_valid_q;
        xfer_cnt = xfer_cnt_q;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a 4-bit transfer counter.
// Inputs change on the falling edge; checks run 1ns later, so gnt reflects
// the new inputs and registered outputs reflect the last rising edge.
module tb_mux_rr_arbiter;

    localparam int unsigned DW    = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [DW-1:0]    a, b, c, d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [DW-1:0]    y_data;
    logic             y_valid;
    logic             y_ready;
    logic [CNT_W-1:0] xfer_cnt;

    int unsigned n_checks;
    int unsigned n_pass;

    mux_rr_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .gnt      (gnt),
        .sel      (sel),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (one rising edge in between).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Pulse reset between rising edges.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        req      = 4'b1111;
        a        = '0;
        b        = '0;
        c        = '0;
        d        = '0;
        y_ready  = 1'b0;
        #1;

        // Power-up reset: outputs clear and gnt suppressed despite requests.
        check("init_gnt",     32'(gnt),      32'h0);
        check("init_valid",   32'(y_valid),  32'h0);
        check("init_sel",     32'(sel),      32'h0);
        check("init_data",    32'(y_data),   32'h0);
        check("init_cnt",     32'(xfer_cnt), 32'h0);

        next_cycle();
        req = 4'b0000;
        rst = 1'b0;

        // Single request from b with downstream ready.
        next_cycle();
        req     = 4'b0010;
        b       = 4'hA;
        y_ready = 1'b1;
        #1;
        check("single_gnt", 32'(gnt), 32'h2);
        next_cycle();
        req = 4'b0000;
        #1;
        check("single_valid", 32'(y_valid),  32'h1);
        check("single_data",  32'(y_data),   32'hA);
        check("single_sel",   32'(sel),      32'h1);
        check("single_cnt0",  32'(xfer_cnt), 32'h0);
        check("single_nogn",  32'(gnt),      32'h0);
        next_cycle();
        #1;
        check("single_cnt1",  32'(xfer_cnt), 32'h1);
        check("idle_valid",   32'(y_valid),  32'h0);
        check("idle_gnt",     32'(gnt),      32'h0);
        next_cycle();
        #1;
        check("idle_cnt_hold", 32'(xfer_cnt), 32'h1);

        // Fairness: all four held, stream a,b,c,d,a with no bubbles.
        pulse_reset();
        next_cycle();
        req = 4'b1111;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            if (i > 0) begin
                check($sformatf("rr_data%0d", i), 32'(y_data), 32'((i - 1) % 4 + 1));
                check($sformatf("rr_valid%0d", i), 32'(y_valid), 32'h1);
            end
            next_cycle();
        end
        req = 4'b0000;
        #1;
        check("rr_data4",  32'(y_data), 32'h1);
        check("rr_sel4",   32'(sel),    32'h0);
        check("rr_drain_gnt", 32'(gnt), 32'h0);
        next_cycle();
        #1;
        check("rr_cnt",    32'(xfer_cnt), 32'h5);
        check("rr_idle",   32'(y_valid),  32'h0);

        // Backpressure: a wins, stalls hold data and suppress gnt, then c.
        pulse_reset();
        next_cycle();
        req     = 4'b0101;
        a       = 4'h5;
        c       = 4'h7;
        y_ready = 1'b0;
        #1;
        check("bp_gnt_first", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check($sformatf("bp_stall_gnt%0d", i),  32'(gnt),     32'h0);
            check($sformatf("bp_stall_data%0d", i), 32'(y_data),  32'h5);
            check($sformatf("bp_stall_sel%0d", i),  32'(sel),     32'h0);
            check($sformatf("bp_stall_vld%0d", i),  32'(y_valid), 32'h1);
        end
        check("bp_stall_cnt", 32'(xfer_cnt), 32'h0);
        y_ready = 1'b1;
        #1;
        check("bp_gnt_c", 32'(gnt), 32'h4);
        next_cycle();
        #1;
        check("bp_data_c", 32'(y_data),   32'h7);
        check("bp_sel_c",  32'(sel),      32'h2);
        check("bp_cnt",    32'(xfer_cnt), 32'h1);

        // Reset mid-VALID clears everything before any clock edge.
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(y_valid),  32'h0);
        check("rst_sel",   32'(sel),      32'h0);
        check("rst_data",  32'(y_data),   32'h0);
        check("rst_cnt",   32'(xfer_cnt), 32'h0);
        check("rst_gnt",   32'(gnt),      32'h0);
        rst = 1'b0;
        req = 4'b0000;

        // Counter wrap: 17 accepted transfers leave a 4-bit count at 1.
        next_cycle();
        req     = 4'b0001;
        a       = 4'h9;
        y_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                #1;
                check("wrap_cnt15", 32'(xfer_cnt), 32'hF);
            end
            next_cycle();
        end
        req = 4'b0000;
        next_cycle();
        #1;
        check("wrap_cnt1",  32'(xfer_cnt), 32'h1);
        check("wrap_idle",  32'(y_valid),  32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
